rpl_match_scheduler: RTL and testbench

- Shares one RPL byte-code VM core between N_REQ match requesters.
- Round-robin arbitrates requests and launches the core with a start PC and input position.
- Enforces a per-match instruction budget and backtrack-stack depth limits, then returns matched/end_pos/status to the winning requester.
- Sits between the request fabric and the VM core.

---
 rtl/rpl_match_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_rpl_match_scheduler.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpl_match_scheduler.sv
// rpl_match_scheduler: shares one RPL byte-code VM core between N_REQ requesters.
// Round-robin grant, one match in flight, instruction budget and backtrack depth
// policing, response returned to the granted requester.
//
// state        | meaning
// S_IDLE       | waiting for a request; grant one, latch pc/pos/id
// S_LAUNCH     | core_start pulse; step/depth counters and budget snapshot set up
// S_RUN        | core executing; done / stack / budget checks every cycle
// S_ABORT_WAIT | core_abort held until the core reports done
// S_RESP       | response presented until rsp_ready
module rpl_match_scheduler #(
  parameter int N_REQ    = 4,
  parameter int PC_W     = 16,
  parameter int POS_W    = 16,
  parameter int BUDGET_W = 24,
  parameter int BT_DEPTH = 100,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*PC_W-1:0]    req_pc,
  input  logic [N_REQ*POS_W-1:0]   req_pos,
  input  logic [BUDGET_W-1:0]      cfg_budget,
  output logic                     core_start,
  output logic [PC_W-1:0]          core_pc,
  output logic [POS_W-1:0]         core_pos,
  output logic                     core_abort,
  input  logic                     core_step,
  input  logic                     core_bt_push,
  input  logic                     core_bt_pop,
  input  logic                     core_done,
  input  logic                     core_end,
  input  logic                     core_matched,
  input  logic [POS_W-1:0]         core_end_pos,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_matched,
  output logic [POS_W-1:0]         rsp_end_pos,
  output logic [1:0]               rsp_status
);

  // Extra bit so a pop at depth 0 alongside core_done wraps to a value != 1.
  localparam int DEPTH_W = $clog2(BT_DEPTH + 1) + 1;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_BUDGET   = 2'd1;
  localparam logic [1:0] ST_OVERFLOW = 2'd2;
  localparam logic [1:0] ST_STACK    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_ABORT_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]     last_grant, id_q, grant_idx, cand;
  logic                grant_found;
  logic [PC_W-1:0]     pc_q;
  logic [POS_W-1:0]    pos_q, end_pos_q;
  logic [BUDGET_W-1:0] budget_q, step_cnt;
  logic [BUDGET_W:0]   step_plus;
  logic [DEPTH_W-1:0]  depth, depth_post;
  logic [1:0]          status_q;
  logic                matched_q;
  logic                push_only, pop_only, underflow, overflow, budget_hit;

  assign core_pc     = pc_q;
  assign core_pos    = pos_q;
  assign rsp_id      = id_q;
  assign rsp_matched = matched_q;
  assign rsp_end_pos = end_pos_q;
  assign rsp_status  = status_q;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(last_grant) + i) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Per-cycle depth update and the three abort triggers seen in RUN.
  always_comb begin
    push_only  = core_bt_push & ~core_bt_pop;
    pop_only   = core_bt_pop & ~core_bt_push;
    depth_post = depth;
    if (push_only)
      depth_post = depth + DEPTH_W'(1);
    else if (pop_only)
      depth_post = depth - DEPTH_W'(1);
    underflow  = pop_only && (depth == '0);
    overflow   = push_only && (depth_post == DEPTH_W'(BT_DEPTH));
    step_plus  = {1'b0, step_cnt} + (BUDGET_W+1)'(1);
    budget_hit = core_step && (budget_q != '0) && (step_plus > {1'b0, budget_q});
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next state and handshake outputs; req_ready is suppressed while reset is held
  // so no requester sees an accept that the registers never captured.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_found && rst_n) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt            = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_start = 1'b1;
        state_nxt  = S_RUN;
      end
      S_RUN: begin
        if (core_done)
          state_nxt = S_RESP;
        else if (underflow || overflow || budget_hit)
          state_nxt = S_ABORT_WAIT;
      end
      S_ABORT_WAIT: begin
        if (core_done)
          state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, counters, result capture and registered abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(N_REQ - 1);
      id_q       <= '0;
      pc_q       <= '0;
      pos_q      <= '0;
      budget_q   <= '0;
      step_cnt   <= '0;
      depth      <= '0;
      status_q   <= ST_OK;
      matched_q  <= 1'b0;
      end_pos_q  <= '0;
      core_abort <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            id_q  <= grant_idx;
            pc_q  <= req_pc[int'(grant_idx)*PC_W +: PC_W];
            pos_q <= req_pos[int'(grant_idx)*POS_W +: POS_W];
          end
        end
        S_LAUNCH: begin
          step_cnt <= '0;
          depth    <= DEPTH_W'(1);
          budget_q <= cfg_budget;
        end
        S_RUN: begin
          if (core_step && (step_cnt != '1))
            step_cnt <= step_cnt + BUDGET_W'(1);
          depth <= depth_post;
          if (core_done) begin
            matched_q <= core_matched;
            end_pos_q <= core_matched ? core_end_pos : pos_q;
            status_q  <= (core_end && (depth_post != DEPTH_W'(1))) ? ST_STACK : ST_OK;
          end else if (underflow) begin
            status_q   <= ST_STACK;
            core_abort <= 1'b1;
          end else if (overflow) begin
            status_q   <= ST_OVERFLOW;
            core_abort <= 1'b1;
          end else if (budget_hit) begin
            status_q   <= ST_BUDGET;
            core_abort <= 1'b1;
          end
        end
        S_ABORT_WAIT: begin
          if (core_done) begin
            core_abort <= 1'b0;
            matched_q  <= 1'b0;
            end_pos_q  <= pos_q;
          end
        end
        S_RESP: begin
          if (rsp_ready)
            last_grant <= id_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rpl_match_scheduler.sv
// Bench for rpl_match_scheduler: a scripted core model drives the VM-side inputs
// one entry per RUN cycle; expectations come from a rule-level reference model.
module tb_rpl_match_scheduler;
   localparam int N_REQ    = 4;
   localparam int PC_W     = 16;
   localparam int POS_W    = 16;
   localparam int BUDGET_W = 24;
   localparam int BT_DEPTH = 100;
   localparam int ID_W     = 2;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [N_REQ-1:0]       req_valid, req_ready;
   logic [N_REQ*PC_W-1:0]  req_pc;
   logic [N_REQ*POS_W-1:0] req_pos;
   logic [BUDGET_W-1:0]    cfg_budget;
   logic                   core_start, core_abort;
   logic [PC_W-1:0]        core_pc;
   logic [POS_W-1:0]       core_pos;
   logic                   core_step, core_bt_push, core_bt_pop, core_done, core_end, core_matched;
   logic [POS_W-1:0]       core_end_pos;
   logic                   rsp_valid, rsp_ready, rsp_matched;
   logic [ID_W-1:0]        rsp_id;
   logic [POS_W-1:0]       rsp_end_pos;
   logic [1:0]             rsp_status;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit step, push, pop, done, endf, matched;
      int end_pos;
   } ev_t;

   ev_t scr[$];
   int  model_last;
   bit  junk;

   rpl_match_scheduler #(
      .N_REQ(N_REQ), .PC_W(PC_W), .POS_W(POS_W), .BUDGET_W(BUDGET_W), .BT_DEPTH(BT_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc), .req_pos(req_pos),
      .cfg_budget(cfg_budget),
      .core_start(core_start), .core_pc(core_pc), .core_pos(core_pos), .core_abort(core_abort),
      .core_step(core_step), .core_bt_push(core_bt_push), .core_bt_pop(core_bt_pop),
      .core_done(core_done), .core_end(core_end), .core_matched(core_matched),
      .core_end_pos(core_end_pos),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_matched(rsp_matched), .rsp_end_pos(rsp_end_pos), .rsp_status(rsp_status)
   );

   always #5 clk = ~clk;

   // Reference: walk the script applying the match rules in priority order.
   function automatic void model(input int budget, input int pos, output int t,
                                 output int status, output bit aborted,
                                 output bit matched, output int end_pos);
      int depth;
      int steps;
      int nd;
      depth = 1; steps = 0;
      t = -1; status = 0; aborted = 0; matched = 0; end_pos = pos;
      foreach (scr[i]) begin
         nd = depth + (scr[i].push ? 1 : 0) - (scr[i].pop ? 1 : 0);
         if (scr[i].done) begin
            t = i; matched = scr[i].matched;
            end_pos = matched ? scr[i].end_pos : pos;
            status = (scr[i].endf && nd != 1) ? 3 : 0;
            return;
         end
         if (scr[i].pop && !scr[i].push && depth == 0) begin
            t = i; status = 3; aborted = 1; return;
         end
         if (scr[i].push && !scr[i].pop && nd == BT_DEPTH) begin
            t = i; status = 2; aborted = 1; return;
         end
         if (budget != 0 && scr[i].step && steps + 1 > budget) begin
            t = i; status = 1; aborted = 1; return;
         end
         depth = nd;
         if (scr[i].step) steps++;
      end
   endfunction

   function automatic int rr_pick(input int last, input bit [N_REQ-1:0] mask);
      for (int i = 1; i <= N_REQ; i++)
         if (mask[(last + i) % N_REQ]) return (last + i) % N_REQ;
      return -1;
   endfunction

   task automatic add(input bit step, input bit push, input bit pop, input bit done,
                      input bit endf, input bit matched, input int end_pos);
      ev_t e;
      e.step = step; e.push = push; e.pop = pop; e.done = done;
      e.endf = endf; e.matched = matched; e.end_pos = end_pos;
      scr.push_back(e);
   endtask

   task automatic set_req(input int r, input int pc, input int pos);
      req_pc[r*PC_W +: PC_W]    = PC_W'(pc);
      req_pos[r*POS_W +: POS_W] = POS_W'(pos);
   endtask

   // Core inputs while the scheduler should ignore them: zero, or noise in random runs.
   task automatic core_quiet();
      if (junk) begin
         core_step = 1'($urandom_range(0, 1)); core_bt_push = 1'($urandom_range(0, 1));
         core_bt_pop = 1'($urandom_range(0, 1)); core_done = 1'($urandom_range(0, 1));
         core_end = 1'($urandom_range(0, 1)); core_matched = 1'($urandom_range(0, 1));
         core_end_pos = POS_W'($urandom);
      end else begin
         core_step = 0; core_bt_push = 0; core_bt_pop = 0; core_done = 0;
         core_end = 0; core_matched = 0; core_end_pos = '0;
      end
   endtask

   task automatic core_zero();
      core_step = 0; core_bt_push = 0; core_bt_pop = 0; core_done = 0;
      core_end = 0; core_matched = 0; core_end_pos = '0;
   endtask

   // One complete match: accept, launch, scripted run (with abort handling), response.
   task automatic do_match(input bit [N_REQ-1:0] mask, input int budget, input int abort_lat,
                           input int rdy_delay, input string tag);
      int w, t, st, ep, k_rsp, aborts;
      bit ab, m, got, exp_abort;
      logic [PC_W-1:0]  epc;
      logic [POS_W-1:0] epos;
      logic [N_REQ-1:0] exp_rdy;
      w = rr_pick(model_last, mask);
      epc = req_pc[w*PC_W +: PC_W];
      epos = req_pos[w*POS_W +: POS_W];
      model(budget, int'(epos), t, st, ab, m, ep);
      exp_rdy = N_REQ'(1) << w;

      @(negedge clk);
      req_valid = mask; cfg_budget = BUDGET_W'(budget); rsp_ready = 0; core_quiet();
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
         errors++;
         $display("FAIL %s grant: req_ready=%b want %b", tag, req_ready, exp_rdy);
      end

      @(negedge clk);
      core_quiet();
      checks++;
      if (core_start !== 1'b1 || core_pc !== epc || core_pos !== epos || req_ready !== '0) begin
         errors++;
         $display("FAIL %s launch: start=%b pc=%h pos=%h ready=%b want 1 %h %h 0",
                  tag, core_start, core_pc, core_pos, req_ready, epc, epos);
      end

      aborts = 0; got = 0; k_rsp = -1;
      for (int k = 0; k < 400 && !got; k++) begin
         @(negedge clk);
         core_zero();
         cfg_budget = BUDGET_W'($urandom);
         exp_abort = ab && (k > t) && (k <= t + 1 + abort_lat);
         checks++;
         if (core_abort !== exp_abort || core_start !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL %s run k=%0d: abort=%b start=%b ready=%b want %b 0 0",
                     tag, k, core_abort, core_start, req_ready, exp_abort);
         end
         if (rsp_valid === 1'b1) begin
            got = 1; k_rsp = k;
         end else begin
            if (k < scr.size()) begin
               core_step = scr[k].step; core_bt_push = scr[k].push; core_bt_pop = scr[k].pop;
               if (!(ab && k > t)) begin
                  core_done = scr[k].done; core_end = scr[k].endf;
                  core_matched = scr[k].matched; core_end_pos = POS_W'(scr[k].end_pos);
               end
            end
            if (ab && k > t) begin
               aborts++;
               if (aborts == abort_lat + 1) begin
                  core_done = 1; core_end = 1'($urandom_range(0, 1));
                  core_matched = 1; core_end_pos = POS_W'($urandom);
               end
            end
         end
      end

      checks++;
      if (!got || k_rsp != (ab ? t + 2 + abort_lat : t + 1)) begin
         errors++;
         $display("FAIL %s rsp_latency: got=%0d k=%0d want k=%0d", tag, got, k_rsp,
                  ab ? t + 2 + abort_lat : t + 1);
         if (!got) begin
            req_valid = '0; core_zero();
            return;
         end
      end

      core_quiet();
      for (int d = 0; d <= rdy_delay; d++) begin
         if (d > 0) begin
            @(negedge clk);
            core_quiet();
         end
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(w) || rsp_matched !== m ||
             rsp_end_pos !== POS_W'(ep) || rsp_status !== 2'(st) ||
             core_pc !== epc || core_pos !== epos || req_ready !== '0 || core_abort !== 1'b0) begin
            errors++;
            $display("FAIL %s resp d=%0d: v=%b id=%0d m=%b pos=%0d st=%0d pc=%h rdy=%b abort=%b want 1 %0d %b %0d %0d %h 0 0",
                     tag, d, rsp_valid, rsp_id, rsp_matched, rsp_end_pos, rsp_status, core_pc,
                     req_ready, core_abort, w, m, ep, st, epc);
         end
         if (d == rdy_delay) rsp_ready = 1;
      end
      @(posedge clk);
      #1;
      rsp_ready = 0; req_valid = '0; core_zero();
      checks++;
      if (rsp_valid !== 1'b0 || core_start !== 1'b0) begin
         errors++;
         $display("FAIL %s resp_exit: rsp_valid=%b core_start=%b want 0 0", tag, rsp_valid, core_start);
      end
      model_last = w;
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if (req_ready !== '0 || core_start !== 0 || core_pc !== '0 || core_pos !== '0 ||
          core_abort !== 0 || rsp_valid !== 0 || rsp_id !== '0 || rsp_matched !== 0 ||
          rsp_end_pos !== '0 || rsp_status !== '0) begin
         errors++;
         $display("FAIL %s: rdy=%b st=%b pc=%h pos=%h ab=%b rv=%b id=%0d m=%b ep=%0d s=%0d want all 0",
                  tag, req_ready, core_start, core_pc, core_pos, core_abort, rsp_valid, rsp_id,
                  rsp_matched, rsp_end_pos, rsp_status);
      end
   endtask

   task automatic test_reset();
      rst_n = 0; req_valid = '0; req_pc = '0; req_pos = '0; cfg_budget = '0; rsp_ready = 0;
      junk = 0; core_zero();
      repeat (3) @(negedge clk);
      check_all_zero("reset_values");
      rst_n = 1;
      model_last = N_REQ - 1;
   endtask

   task automatic test_round_robin();
      for (int r = 0; r < N_REQ; r++) set_req(r, 16'h100 + r, 20 + r);
      for (int i = 0; i < 5; i++) begin
         scr.delete();
         add(1, 0, 0, 1, 1, 1, 50 + i);
         do_match(4'hF, 0, 0, 0, "round_robin");
      end
   endtask

   task automatic test_single();
      set_req(2, 16'h0010, 5);
      scr.delete();
      for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 0, 1, 1, 1, 12);
      do_match(4'b0100, 0, 0, 0, "single");
   endtask

   task automatic test_budget();
      set_req(1, 16'h0200, 33);
      scr.delete();
      for (int i = 0; i < 40; i++) add(1, 0, 0, 0, 0, 0, 0);
      do_match(4'b0010, 10, 3, 1, "budget");
   endtask

   task automatic test_overflow();
      set_req(3, 16'h0300, 44);
      scr.delete();
      for (int i = 0; i < 99; i++) add(1, 1, 0, 0, 0, 0, 0);
      do_match(4'b1000, 0, 2, 0, "overflow");
   endtask

   task automatic test_stack_err();
      set_req(0, 16'h0400, 11);
      scr.delete();
      for (int i = 0; i < 98; i++) add(0, 1, 0, 0, 0, 0, 0);
      add(1, 0, 0, 1, 1, 1, 60);
      do_match(4'b0001, 0, 0, 0, "stack_err_depth");
   endtask

   task automatic test_underflow();
      set_req(2, 16'h0500, 17);
      scr.delete();
      add(1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0);
      do_match(4'b0100, 0, 1, 0, "underflow");
   endtask

   task automatic test_simultaneous();
      set_req(1, 16'h0600, 8);
      scr.delete();
      for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 1, 1, 1, 33);
      do_match(4'b0010, 5, 0, 0, "done_vs_budget");
      scr.delete();
      for (int i = 0; i < 98; i++) add(0, 1, 0, 0, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 99);
      do_match(4'b0010, 0, 0, 0, "pushpop_at_99");
   endtask

   task automatic test_unmatched();
      set_req(3, 16'h0700, 7);
      scr.delete();
      add(1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 1, 1, 0, 40);
      do_match(4'b1000, 0, 0, 2, "unmatched");
   endtask

   task automatic test_reset_mid();
      set_req(1, 16'hBEEF, 9);
      @(negedge clk);
      req_valid = 4'b0010; cfg_budget = '0;
      @(negedge clk);
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         core_step = 1;
      end
      checks++;
      if (core_pc !== 16'hBEEF || core_pos !== 16'd9) begin
         errors++;
         $display("FAIL reset_mid_pre: pc=%h pos=%0d want beef 9", core_pc, core_pos);
      end
      #2 rst_n = 0;
      #1;
      check_all_zero("reset_mid_outputs");
      core_zero();
      @(negedge clk);
      rst_n = 1;
      model_last = N_REQ - 1;
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || core_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_no_resp: rsp_valid=%b core_start=%b want 0 0", rsp_valid, core_start);
      end
      for (int r = 0; r < N_REQ; r++) set_req(r, 16'h800 + r, 70 + r);
      scr.delete();
      add(1, 0, 0, 1, 1, 1, 21);
      do_match(4'hF, 0, 1, 0, "after_reset_first");
   endtask

   task automatic test_random();
      int len;
      ev_t e;
      junk = 1;
      for (int it = 0; it < 30; it++) begin
         for (int r = 0; r < N_REQ; r++) set_req(r, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
         scr.delete();
         len = $urandom_range(1, 20);
         for (int j = 0; j < len; j++) begin
            e.step = ($urandom_range(0, 9) < 7);
            e.push = ($urandom_range(0, 9) < 3);
            e.pop = ($urandom_range(0, 9) < 2);
            e.done = (j == len - 1) || ($urandom_range(0, 19) == 0);
            e.endf = 1'($urandom_range(0, 1));
            e.matched = 1'($urandom_range(0, 1));
            e.end_pos = $urandom_range(0, 65535);
            scr.push_back(e);
         end
         do_match(4'($urandom_range(1, 15)),
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12)),
                  $urandom_range(0, 3), $urandom_range(0, 3), "random");
      end
      junk = 0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_budget();
      test_overflow();
      test_stack_err();
      test_underflow();
      test_simultaneous();
      test_unmatched();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d %s", checks, errors, (errors == 0) ? "PASS" : "FAIL");
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
